// File: rtl/system_qsys_sysid_checker_pkg.sv
// rtl/system_qsys_sysid_checker_pkg.sv - shared FSM encoding and sysid constants
package system_qsys_sysid_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_ID = 3'd1,
    ST_LAT_ID = 3'd2,
    ST_REQ_TS = 3'd3,
    ST_LAT_TS = 3'd4,
    ST_CHECK  = 3'd5,
    ST_FINISH = 3'd6
  } state_e;

  // Word addresses of the sysid control slave; must track the sysid generator.
  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam logic [31:0] DEF_EXPECTED_ID        = 32'd0;
  localparam logic [31:0] DEF_EXPECTED_TIMESTAMP = 32'd1618994540;

  function automatic logic is_read_state(input state_e s);
    return (s == ST_REQ_ID) || (s == ST_LAT_ID) || (s == ST_REQ_TS) || (s == ST_LAT_TS);
  endfunction

endpackage

// File: rtl/system_qsys_avm_single_read.sv
// rtl/system_qsys_avm_single_read.sv - one Avalon-MM read with waitrequest, fixed latency and timeout
module system_qsys_avm_single_read #(
  parameter int READ_LATENCY   = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_active,
  input  logic        i_addr,
  output logic        o_avm_address,
  output logic        o_avm_read,
  input  logic        i_avm_waitrequest,
  input  logic [31:0] i_avm_readdata,
  output logic [31:0] o_data,
  output logic        o_accept,
  output logic        o_valid,
  output logic        o_timeout
);

  localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]   TO_MAX   = TW'(TIMEOUT_CYCLES);
  localparam logic            HAS_LAT  = (READ_LATENCY != 0);
  localparam logic [1:0]      LAT_LAST = 2'((READ_LATENCY != 0) ? (READ_LATENCY - 1) : 0);

  logic [TW-1:0] r_to_cnt;
  logic          r_in_lat;
  logic [1:0]    r_lat_cnt;
  logic          w_accept;
  logic          w_last_lat;

  assign o_avm_address = i_addr;
  assign o_avm_read    = i_active & ~r_in_lat;
  assign w_accept      = o_avm_read & ~i_avm_waitrequest;
  assign w_last_lat    = HAS_LAT & r_in_lat & (r_lat_cnt == LAT_LAST);
  assign o_accept      = w_accept;
  assign o_valid       = HAS_LAT ? w_last_lat : w_accept;
  // A capture on the final allowed cycle wins over the abort.
  assign o_timeout     = i_active & ~o_valid & (r_to_cnt == TO_LAST);
  assign o_data        = i_avm_readdata;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_to_cnt  <= '0;
      r_in_lat  <= 1'b0;
      r_lat_cnt <= '0;
    end else if (!i_active || o_valid || o_timeout) begin
      r_to_cnt  <= '0;
      r_in_lat  <= 1'b0;
      r_lat_cnt <= '0;
    end else begin
      r_to_cnt <= (r_to_cnt == TO_MAX) ? r_to_cnt : r_to_cnt + 1'b1;
      if (w_accept) begin
        r_in_lat  <= 1'b1;
        r_lat_cnt <= '0;
      end else if (r_in_lat) begin
        r_lat_cnt <= r_lat_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/system_qsys_sysid_checker.sv
// rtl/system_qsys_sysid_checker.sv - reads sysid ID and timestamp and compares to build values
module system_qsys_sysid_checker
  import system_qsys_sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = DEF_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEF_EXPECTED_TIMESTAMP,
  parameter int          READ_LATENCY       = 0,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter int          AUTO_START         = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout
);

  state_e      r_state;
  state_e      w_next;
  logic        r_auto;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic        r_timeout;
  logic [31:0] r_id;
  logic [31:0] r_ts;
  logic        w_go;
  logic        w_active;
  logic        w_addr;
  logic [31:0] w_rd_data;
  logic        w_rd_accept;
  logic        w_rd_valid;
  logic        w_rd_timeout;

  assign w_go = start | r_auto;

  system_qsys_avm_single_read #(
    .READ_LATENCY   (READ_LATENCY),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_read (
    .i_clock           (clock),
    .i_reset_n         (reset_n),
    .i_active          (w_active),
    .i_addr            (w_addr),
    .o_avm_address     (avm_address),
    .o_avm_read        (avm_read),
    .i_avm_waitrequest (avm_waitrequest),
    .i_avm_readdata    (avm_readdata),
    .o_data            (w_rd_data),
    .o_accept          (w_rd_accept),
    .o_valid           (w_rd_valid),
    .o_timeout         (w_rd_timeout)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_go) w_next = ST_REQ_ID;
      ST_REQ_ID: begin
        if (w_rd_timeout)     w_next = ST_FINISH;
        else if (w_rd_valid)  w_next = ST_REQ_TS;
        else if (w_rd_accept) w_next = ST_LAT_ID;
      end
      ST_LAT_ID: begin
        if (w_rd_timeout)     w_next = ST_FINISH;
        else if (w_rd_valid)  w_next = ST_REQ_TS;
      end
      ST_REQ_TS: begin
        if (w_rd_timeout)     w_next = ST_FINISH;
        else if (w_rd_valid)  w_next = ST_CHECK;
        else if (w_rd_accept) w_next = ST_LAT_TS;
      end
      ST_LAT_TS: begin
        if (w_rd_timeout)     w_next = ST_FINISH;
        else if (w_rd_valid)  w_next = ST_CHECK;
      end
      ST_CHECK:  w_next = ST_FINISH;
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_active = is_read_state(r_state);
    w_addr   = ((r_state == ST_REQ_TS) || (r_state == ST_LAT_TS)) ? ADDR_TS : ADDR_ID;
  end

  // Sticky status and captured words; they only change at the step that owns them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_auto    <= (AUTO_START != 0);
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
      r_id      <= '0;
      r_ts      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_go) begin
          r_auto    <= 1'b0;
          r_busy    <= 1'b1;
          r_done    <= 1'b0;
          r_pass    <= 1'b0;
          r_timeout <= 1'b0;
        end
        ST_REQ_ID, ST_LAT_ID: begin
          if (w_rd_valid) r_id <= w_rd_data;
          if (w_rd_timeout) begin
            r_timeout <= 1'b1;
            r_pass    <= 1'b0;
          end
        end
        ST_REQ_TS, ST_LAT_TS: begin
          if (w_rd_valid) r_ts <= w_rd_data;
          if (w_rd_timeout) begin
            r_timeout <= 1'b1;
            r_pass    <= 1'b0;
          end
        end
        ST_CHECK:  r_pass <= (r_id == EXPECTED_ID) && (r_ts == EXPECTED_TIMESTAMP);
        ST_FINISH: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign id_value        = r_id;
  assign timestamp_value = r_ts;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign timeout         = r_timeout;

endmodule

// File: tb/tb_system_qsys_sysid_checker.sv
// tb/tb_system_qsys_sysid_checker.sv - checks two checker configurations against a duration model
module tb_system_qsys_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1618994540;
  localparam int          STUCK  = 100000;

  typedef struct {
    int          s0, s1;
    logic [31:0] d0, d1;
    int          cyc0, cyc1;
    bit          p0, p1, t0, t1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  start_v, avm_read_v, avm_addr_v, wait_v, busy_v, done_v, pass_v, to_v;
  logic [31:0] rdata_v [2];
  logic [31:0] id_v [2];
  logic [31:0] ts_v [2];

  int          S0, S1;
  logic [31:0] M0, M1;
  int          scnt [2];
  int          kpend [2];
  logic        paddr [2];
  bit          prev_rd [2];
  bit          prev_wait [2];
  logic        prev_addr [2];
  int          viol [2];
  int          rd1_cnt [2];
  logic [31:0] eid [2];
  logic [31:0] ets [2];
  int          n_vec = 0;
  int          n_err = 0;
  vec_t        tab [$];

  always #5 clk = ~clk;

  system_qsys_sysid_checker #(.READ_LATENCY(0), .TIMEOUT_CYCLES(255), .AUTO_START(1)) u_dut0 (
    .clock(clk), .reset_n(rst_n), .start(start_v[0]),
    .avm_address(avm_addr_v[0]), .avm_read(avm_read_v[0]), .avm_waitrequest(wait_v[0]),
    .avm_readdata(rdata_v[0]), .id_value(id_v[0]), .timestamp_value(ts_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .timeout(to_v[0]));

  system_qsys_sysid_checker #(.READ_LATENCY(2), .TIMEOUT_CYCLES(8), .AUTO_START(1)) u_dut1 (
    .clock(clk), .reset_n(rst_n), .start(start_v[1]),
    .avm_address(avm_addr_v[1]), .avm_read(avm_read_v[1]), .avm_waitrequest(wait_v[1]),
    .avm_readdata(rdata_v[1]), .id_value(id_v[1]), .timestamp_value(ts_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .timeout(to_v[1]));

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic int tmo_of(input int d);
    return (d == 0) ? 255 : 8;
  endfunction

  // Each read occupies stall + 1 + latency cycles; it aborts if that exceeds the timeout.
  function automatic void model(input int lat, input int tmo, input int s0, input int s1,
                                output int cyc, output bit to0, output bit to1);
    int t0, t1;
    t0  = s0 + 1 + lat;
    t1  = s1 + 1 + lat;
    to0 = (t0 > tmo);
    to1 = !to0 && (t1 > tmo);
    cyc = to0 ? tmo + 1 : (to1 ? t0 + tmo + 1 : t0 + t1 + 2);
  endfunction

  function automatic vec_t mk(input int s0, input int s1, input logic [31:0] d0, input logic [31:0] d1,
                              input int c0, input int c1, input bit p0, input bit p1,
                              input bit t0, input bit t1);
    vec_t v;
    v.s0 = s0; v.s1 = s1; v.d0 = d0; v.d1 = d1;
    v.cyc0 = c0; v.cyc1 = c1; v.p0 = p0; v.p1 = p1; v.t0 = t0; v.t1 = t1;
    return v;
  endfunction

  function automatic vec_t mk_rand();
    vec_t v;
    int   c;
    bit   a, b;
    v.s0 = ($urandom_range(0, 5) == 0) ? 7 : int'($urandom_range(0, 3));
    v.s1 = ($urandom_range(0, 5) == 0) ? 7 : int'($urandom_range(0, 3));
    v.d0 = $urandom_range(0, 1) ? EXP_ID : $urandom;
    v.d1 = $urandom_range(0, 1) ? EXP_TS : (EXP_TS ^ (32'd1 << $urandom_range(0, 31)));
    model(lat_of(0), tmo_of(0), v.s0, v.s1, c, a, b);
    v.cyc0 = c; v.t0 = a | b; v.p0 = !(a | b) && (v.d0 == EXP_ID) && (v.d1 == EXP_TS);
    model(lat_of(1), tmo_of(1), v.s0, v.s1, c, a, b);
    v.cyc1 = c; v.t1 = a | b; v.p1 = !(a | b) && (v.d0 == EXP_ID) && (v.d1 == EXP_TS);
    return v;
  endfunction

  // Slave model: per-address stall count, then data valid only in the capture cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic        w;
      logic [31:0] data;
      data = $urandom;
      w    = 1'b0;
      if (!rst_n) begin
        scnt[d] = 0; kpend[d] = 0; prev_rd[d] = 1'b0; prev_wait[d] = 1'b0; prev_addr[d] = 1'b0;
      end else begin
        if (prev_rd[d] && prev_wait[d] && busy_v[d] && !to_v[d] &&
            (!avm_read_v[d] || avm_addr_v[d] != prev_addr[d]))
          viol[d]++;
        if (!avm_read_v[d] || !prev_rd[d] || avm_addr_v[d] != prev_addr[d]) scnt[d] = 0;
        w = avm_read_v[d] && (scnt[d] < (avm_addr_v[d] ? S1 : S0));
        if (w) scnt[d]++;
        if (kpend[d] > 0) begin
          kpend[d]--;
          if (kpend[d] == 0) data = paddr[d] ? M1 : M0;
        end
        if (avm_read_v[d] && !w) begin
          if (lat_of(d) == 0) data = avm_addr_v[d] ? M1 : M0;
          else begin
            kpend[d] = lat_of(d);
            paddr[d] = avm_addr_v[d];
          end
        end
        if (avm_read_v[d] && avm_addr_v[d]) rd1_cnt[d]++;
        prev_rd[d]   = avm_read_v[d];
        prev_addr[d] = avm_addr_v[d];
        prev_wait[d] = w;
      end
      wait_v[d]  = w;
      rdata_v[d] = data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s dut%0d busy", tag, d), {31'd0, busy_v[d]}, 32'd0);
      chk($sformatf("%s dut%0d done", tag, d), {31'd0, done_v[d]}, 32'd0);
      chk($sformatf("%s dut%0d pass", tag, d), {31'd0, pass_v[d]}, 32'd0);
      chk($sformatf("%s dut%0d timeout", tag, d), {31'd0, to_v[d]}, 32'd0);
      chk($sformatf("%s dut%0d read", tag, d), {31'd0, avm_read_v[d]}, 32'd0);
      chk($sformatf("%s dut%0d addr", tag, d), {31'd0, avm_addr_v[d]}, 32'd0);
      chk($sformatf("%s dut%0d id", tag, d), id_v[d], 32'd0);
      chk($sformatf("%s dut%0d ts", tag, d), ts_v[d], 32'd0);
      eid[d] = 32'd0;
      ets[d] = 32'd0;
    end
  endtask

  task automatic run_vec(input vec_t v, input bit by_reset, input string tag);
    int cyc [2];
    bit pe [2];
    bit te [2];
    int got [2];
    bit seen [2];
    int v0 [2];
    int r1 [2];
    int bound, c;
    bit a, b;
    cyc[0] = v.cyc0; cyc[1] = v.cyc1; pe[0] = v.p0; pe[1] = v.p1; te[0] = v.t0; te[1] = v.t1;
    S0 = v.s0; S1 = v.s1; M0 = v.d0; M1 = v.d1;
    for (int d = 0; d < 2; d++) begin
      v0[d] = viol[d]; r1[d] = rd1_cnt[d]; seen[d] = 1'b0; got[d] = 0;
    end
    @(negedge clk);
    if (by_reset) rst_n = 1'b1;
    else start_v = 2'b11;
    @(negedge clk);
    start_v = 2'b00;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s dut%0d busy at start", tag, d), {31'd0, busy_v[d]}, 32'd1);
      chk($sformatf("%s dut%0d done cleared", tag, d), {31'd0, done_v[d]}, 32'd0);
    end
    bound = ((cyc[0] > cyc[1]) ? cyc[0] : cyc[1]) + 4;
    for (int n = 1; n <= bound && !(seen[0] && seen[1]); n++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        if (!seen[d] && done_v[d]) begin
          seen[d] = 1'b1;
          got[d]  = n;
        end
    end
    for (int d = 0; d < 2; d++) begin
      model(lat_of(d), tmo_of(d), v.s0, v.s1, c, a, b);
      if (!a) eid[d] = v.d0;
      if (!a && !b) ets[d] = v.d1;
      chk($sformatf("%s dut%0d cycles to done", tag, d), got[d], cyc[d]);
      chk($sformatf("%s dut%0d pass", tag, d), {31'd0, pass_v[d]}, {31'd0, pe[d]});
      chk($sformatf("%s dut%0d timeout", tag, d), {31'd0, to_v[d]}, {31'd0, te[d]});
      chk($sformatf("%s dut%0d busy at done", tag, d), {31'd0, busy_v[d]}, 32'd0);
      chk($sformatf("%s dut%0d id_value", tag, d), id_v[d], eid[d]);
      chk($sformatf("%s dut%0d timestamp_value", tag, d), ts_v[d], ets[d]);
      chk($sformatf("%s dut%0d addr1 read seen", tag, d),
          {31'd0, (rd1_cnt[d] != r1[d])}, {31'd0, !a});
      chk($sformatf("%s dut%0d stall stability", tag, d), viol[d], v0[d]);
    end
  endtask

  initial begin
    rst_n = 1'b0; start_v = 2'b00;
    S0 = 0; S1 = 0; M0 = EXP_ID; M1 = EXP_TS;
    for (int d = 0; d < 2; d++) begin viol[d] = 0; rd1_cnt[d] = 0; end

    tab.push_back(mk(0, 0, EXP_ID, EXP_TS, 4, 8, 1, 1, 0, 0));
    tab.push_back(mk(0, 0, EXP_ID, EXP_TS + 32'd1, 4, 8, 0, 0, 0, 0));
    tab.push_back(mk(3, 3, EXP_ID, EXP_TS, 10, 14, 1, 1, 0, 0));
    tab.push_back(mk(STUCK, 0, EXP_ID, EXP_TS, 256, 9, 0, 0, 1, 1));
    tab.push_back(mk(0, 7, EXP_ID, EXP_TS, 11, 12, 1, 0, 0, 1));
    tab.push_back(mk(1, 2, 32'd5, EXP_TS, 7, 11, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) tab.push_back(mk_rand());

    repeat (3) @(negedge clk);
    check_zero("reset");
    run_vec(tab[0], 1'b1, "autostart");
    for (int i = 1; i < tab.size(); i++) run_vec(tab[i], 1'b0, $sformatf("vec%0d", i));

    // Start while busy and in the done-rising cycle is dropped; one cycle later it runs.
    S0 = 0; S1 = 0; M0 = EXP_ID; M1 = EXP_TS;
    @(negedge clk); start_v = 2'b01;
    @(negedge clk); start_v = 2'b00;
    @(negedge clk); start_v = 2'b01;
    @(negedge clk); start_v = 2'b00;
    @(negedge clk); start_v = 2'b01;
    @(negedge clk); start_v = 2'b00;
    chk("ignore done rises", {31'd0, done_v[0]}, 32'd1);
    chk("ignore busy low", {31'd0, busy_v[0]}, 32'd0);
    @(negedge clk);
    chk("ignore still idle", {31'd0, busy_v[0]}, 32'd0);
    chk("ignore pass kept", {31'd0, pass_v[0]}, 32'd1);
    start_v = 2'b01;
    @(negedge clk); start_v = 2'b00;
    chk("restart busy", {31'd0, busy_v[0]}, 32'd1);
    chk("restart done clear", {31'd0, done_v[0]}, 32'd0);
    chk("restart pass clear", {31'd0, pass_v[0]}, 32'd0);
    repeat (3) @(negedge clk);
    chk("restart not early", {31'd0, done_v[0]}, 32'd0);
    @(negedge clk);
    chk("restart done", {31'd0, done_v[0]}, 32'd1);
    chk("restart pass", {31'd0, pass_v[0]}, 32'd1);

    // Asynchronous reset while both instances stall on the timestamp read.
    S0 = 0; S1 = STUCK;
    @(negedge clk); start_v = 2'b11;
    @(negedge clk); start_v = 2'b00;
    repeat (3) @(negedge clk);
    chk("pre-reset read", {30'd0, avm_read_v}, 32'd3);
    chk("pre-reset addr", {30'd0, avm_addr_v}, 32'd3);
    #2 rst_n = 1'b0;
    #1 check_zero("async reset");
    S1 = 0;
    run_vec(tab[0], 1'b1, "post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
